// File: rtl/quad_step_decoder_pkg.sv
// -----------------------------------------------------------------------------
// quad_step_decoder_pkg
//   Shared definitions for the quadrature step decoder:
//     - tracking FSM state encoding
//     - step accumulator width
//     - Gray-code step decode (previous/current AB pair -> direction, illegal)
// -----------------------------------------------------------------------------
package quad_step_decoder_pkg;

    // Signed accumulator width; +/-4 edges plus one overshoot fits in 4 bits.
    localparam int ACC_W = 4;

    typedef enum logic {
        PRIME = 1'b0,   // waiting for synchroniser/filter to settle
        TRACK = 1'b1    // decoding filtered A/B transitions
    } qsd_state_t;

    typedef struct packed {
        logic signed [1:0] dir;      // +1 forward, -1 reverse, 0 no change
        logic              illegal;  // both channels moved at once
    } qsd_step_t;

    // Position of an AB pair along the forward cycle 00 -> 01 -> 11 -> 10.
    // This is the Gray-to-binary conversion of the pair.
    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        return {ab[1], ab[1] ^ ab[0]};
    endfunction

    // The modulo-4 distance between the two positions classifies the move:
    // 1 is one step forward, 3 is one step back, 2 means both bits flipped.
    function automatic qsd_step_t gray_step(input logic [1:0] prev_ab,
                                            input logic [1:0] cur_ab);
        qsd_step_t  s;
        logic [1:0] delta;
        delta     = gray_pos(cur_ab) - gray_pos(prev_ab);
        s.dir     = 2'sd0;
        s.illegal = 1'b0;
        case (delta)
            2'd1:    s.dir = 2'sd1;
            2'd3:    s.dir = -2'sd1;
            2'd2:    s.illegal = 1'b1;
            default: s.dir = 2'sd0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/quad_step_decoder_input_filter.sv
// -----------------------------------------------------------------------------
// quad_input_filter
//   Conditions one raw encoder channel: a SYNC_STAGES-deep synchroniser
//   followed by a persistence filter. The filtered level only follows the
//   synchronised input after it has differed for FILTER_CYCLES consecutive
//   cycles, so shorter glitches never reach the decoder.
//
// Ports
//   clk     in   system clock, rising edge
//   reset   in   asynchronous active-high reset
//   raw_in  in   asynchronous encoder channel
//   level   out  synchronised, glitch-filtered level (registered)
// -----------------------------------------------------------------------------
module quad_input_filter #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic level
);

    localparam int                CNT_W    = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_chain;
    logic                   synced;
    logic [CNT_W-1:0]       persist_cnt;

    assign synced = sync_chain[SYNC_STAGES-1];

    // Synchroniser: raw_in enters at bit 0, the oldest sample sits at the top.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_chain <= '0;
        end else begin
            sync_chain <= {sync_chain[SYNC_STAGES-2:0], raw_in};
        end
    end

    // Persistence filter. The counter holds how many cycles in a row the
    // synchronised level has disagreed with the accepted level; on the cycle
    // that would make it FILTER_CYCLES the new level is taken instead.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level       <= 1'b0;
            persist_cnt <= '0;
        end else if (synced == level) begin
            persist_cnt <= '0;
        end else if (persist_cnt == CNT_LAST) begin
            level       <= synced;
            persist_cnt <= '0;
        end else begin
            persist_cnt <= persist_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/quad_step_decoder.sv
// -----------------------------------------------------------------------------
// quad_step_decoder
//   Front end for the up/down position counter. Both encoder channels are
//   synchronised and glitch-filtered, then the filtered AB pair is Gray-decoded
//   each cycle. Edges are accumulated and one increment/decrement pulse is
//   issued per EDGES_PER_STEP edges in the same direction. A move of both
//   channels at once is illegal: it pulses error, sets error_flag and drops
//   any partial step.
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-high reset
//   a_in        in   encoder channel A (asynchronous)
//   b_in        in   encoder channel B (asynchronous)
//   err_clear   in   synchronous clear of error_flag (a same-cycle error wins)
//   increment   out  one-cycle pulse, one step forward
//   decrement   out  one-cycle pulse, one step reverse
//   error       out  one-cycle pulse on an illegal transition
//   error_flag  out  sticky error indicator
// -----------------------------------------------------------------------------
module quad_step_decoder
    import quad_step_decoder_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_CYCLES  = 4,
    parameter int EDGES_PER_STEP = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic a_in,
    input  logic b_in,
    input  logic err_clear,
    output logic increment,
    output logic decrement,
    output logic error,
    output logic error_flag
);

    // PRIME lasts long enough for a level present at reset release to pass
    // the synchroniser and filter, so prev is captured from settled levels.
    localparam int                    SETTLE_CYCLES = SYNC_STAGES + FILTER_CYCLES + 1;
    localparam int                    SETTLE_W      = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SETTLE_W-1:0]   SETTLE_LAST   = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic signed [ACC_W-1:0] STEP_POS    = ACC_W'(EDGES_PER_STEP);
    localparam logic signed [ACC_W-1:0] STEP_NEG    = -STEP_POS;

    logic                     a_f;
    logic                     b_f;
    logic [1:0]               cur_ab;
    logic [1:0]               prev_ab;
    qsd_state_t               state;
    logic [SETTLE_W-1:0]      settle_cnt;
    qsd_step_t                gstep;
    logic signed [ACC_W-1:0]  dir_ext;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_sum;

    // ---- conditioning: synchroniser + glitch filter per channel ----
    quad_input_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_filter_a (
        .clk    (clk),
        .reset  (reset),
        .raw_in (a_in),
        .level  (a_f)
    );

    quad_input_filter #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_filter_b (
        .clk    (clk),
        .reset  (reset),
        .raw_in (b_in),
        .level  (b_f)
    );

    // ---- decode: Gray step of filtered pair against last sampled pair ----
    assign cur_ab  = {a_f, b_f};
    assign gstep   = gray_step(prev_ab, cur_ab);
    assign dir_ext = {{(ACC_W-2){gstep.dir[1]}}, gstep.dir};
    assign acc_sum = acc + dir_ext;

    // ---- FSM, accumulator and registered outputs ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= PRIME;
            settle_cnt <= '0;
            prev_ab    <= '0;
            acc        <= '0;
            increment  <= 1'b0;
            decrement  <= 1'b0;
            error      <= 1'b0;
            error_flag <= 1'b0;
        end else begin
            increment <= 1'b0;
            decrement <= 1'b0;
            error     <= 1'b0;

            // Clear first so that an error set later in this block wins.
            if (err_clear) begin
                error_flag <= 1'b0;
            end

            case (state)
                PRIME: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        prev_ab    <= cur_ab;
                        acc        <= '0;
                        settle_cnt <= '0;
                        state      <= TRACK;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end

                TRACK: begin
                    prev_ab <= cur_ab;
                    if (gstep.illegal) begin
                        error      <= 1'b1;
                        error_flag <= 1'b1;
                        acc        <= '0;
                    end else if (acc_sum == STEP_POS) begin
                        increment <= 1'b1;
                        acc       <= '0;
                    end else if (acc_sum == STEP_NEG) begin
                        decrement <= 1'b1;
                        acc       <= '0;
                    end else begin
                        // Opposite edges cancel, so a reversal unwinds a
                        // partial step instead of producing a pulse.
                        acc <= acc_sum;
                    end
                end

                default: begin
                    state <= PRIME;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quad_step_decoder.sv
module tb_quad_step_decoder;

    localparam int LAT   = 7;   // SYNC_STAGES + FILTER_CYCLES + 1 with defaults
    localparam int K_INC = 1;
    localparam int K_DEC = 2;
    localparam int K_ERR = 3;

    typedef struct {
        int kind;
        int cyc;
    } evt_t;

    logic clk       = 1'b0;
    logic reset     = 1'b1;
    logic a_in      = 1'b0;
    logic b_in      = 1'b0;
    logic err_clear = 1'b0;

    logic inc4, dec4, err4, flag4;
    logic inc1, dec1, err1, flag1;

    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    evt_t q0[$];
    evt_t q1[$];
    bit   err_at[int];
    int   acc_m[2];
    int   edges_m[2];
    logic exp_flag = 1'b0;
    logic clr_last = 1'b0;
    bit   mon_en   = 1'b0;
    bit   rnd_clr  = 1'b0;
    logic [1:0] cur_ab = 2'b00;

    quad_step_decoder #(
        .SYNC_STAGES(2), .FILTER_CYCLES(4), .EDGES_PER_STEP(4)
    ) dut4 (
        .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .err_clear(err_clear),
        .increment(inc4), .decrement(dec4), .error(err4), .error_flag(flag4)
    );

    quad_step_decoder #(
        .SYNC_STAGES(2), .FILTER_CYCLES(4), .EDGES_PER_STEP(1)
    ) dut1 (
        .clk(clk), .reset(reset), .a_in(a_in), .b_in(b_in), .err_clear(err_clear),
        .increment(inc1), .decrement(dec1), .error(err1), .error_flag(flag1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference model ----------------
    function automatic logic [1:0] fwd_next(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] rev_next(input logic [1:0] s);
        case (s)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    function automatic void push_evt(input int lane, input int kind, input int due);
        evt_t e;
        e.kind = kind;
        e.cyc  = due;
        if (lane == 0) q0.push_back(e);
        else           q1.push_back(e);
    endfunction

    function automatic void model_edge(input logic [1:0] p, input logic [1:0] c, input int due);
        int dir;
        bit bad;
        dir = 0;
        bad = 1'b0;
        if (c == fwd_next(p))      dir = 1;
        else if (c == rev_next(p)) dir = -1;
        else if (c != p)           bad = 1'b1;
        for (int l = 0; l < 2; l++) begin
            if (bad) begin
                acc_m[l] = 0;
                push_evt(l, K_ERR, due);
            end else begin
                acc_m[l] += dir;
                if (acc_m[l] == edges_m[l]) begin
                    push_evt(l, K_INC, due);
                    acc_m[l] = 0;
                end else if (acc_m[l] == -edges_m[l]) begin
                    push_evt(l, K_DEC, due);
                    acc_m[l] = 0;
                end
            end
        end
        if (bad) err_at[due] = 1'b1;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    function automatic int q_size(input int lane);
        return (lane == 0) ? q0.size() : q1.size();
    endfunction

    function automatic int q_front_cyc(input int lane);
        return (lane == 0) ? q0[0].cyc : q1[0].cyc;
    endfunction

    function automatic evt_t q_pop(input int lane);
        if (lane == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic void check_lane(input int lane, input logic inc, input logic dec,
                                       input logic err, input logic flg);
        evt_t e;
        int   kind;
        kind = 0;
        if (inc)      kind = K_INC;
        else if (dec) kind = K_DEC;
        else if (err) kind = K_ERR;
        while (q_size(lane) > 0 && q_front_cyc(lane) < cyc) begin
            e = q_pop(lane);
            checks++;
            errors++;
            $display("FAIL lane%0d missing_pulse: got none by cycle %0d, required kind %0d at cycle %0d",
                     lane, cyc, e.kind, e.cyc);
        end
        checks++;
        if ((int'(inc) + int'(dec) + int'(err)) > 1) begin
            errors++;
            $display("FAIL lane%0d exclusive: got inc=%b dec=%b err=%b at cycle %0d, required at most one",
                     lane, inc, dec, err, cyc);
        end
        checks++;
        if (flg !== exp_flag) begin
            errors++;
            $display("FAIL lane%0d error_flag: got %b at cycle %0d, required %b", lane, flg, cyc, exp_flag);
        end
        if (kind != 0) begin
            checks++;
            if (q_size(lane) == 0) begin
                errors++;
                $display("FAIL lane%0d unexpected_pulse: got kind %0d at cycle %0d, required none",
                         lane, kind, cyc);
            end else begin
                e = q_pop(lane);
                if (e.kind != kind || e.cyc != cyc) begin
                    errors++;
                    $display("FAIL lane%0d pulse: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                             lane, kind, cyc, e.kind, e.cyc);
                end
            end
        end
    endfunction

    always @(negedge clk) begin
        if (!mon_en) begin
            exp_flag = 1'b0;
        end else begin
            if (err_at.exists(cyc)) exp_flag = 1'b1;
            else if (clr_last)      exp_flag = 1'b0;
            check_lane(0, inc4, dec4, err4, flag4);
            check_lane(1, inc1, dec1, err1, flag1);
        end
        clr_last = err_clear;
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string name, input logic got, input logic req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %b, required %b", name, got, req);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_inc4"},  inc4,  1'b0);
        chk({tag, "_dec4"},  dec4,  1'b0);
        chk({tag, "_err4"},  err4,  1'b0);
        chk({tag, "_flag4"}, flag4, 1'b0);
        chk({tag, "_inc1"},  inc1,  1'b0);
        chk({tag, "_dec1"},  dec1,  1'b0);
        chk({tag, "_err1"},  err1,  1'b0);
        chk({tag, "_flag1"}, flag1, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        err_clear = rnd_clr && ($urandom_range(0, 11) == 0);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic step_to(input logic [1:0] nab, input int gap);
        {a_in, b_in} = nab;
        model_edge(cur_ab, nab, cyc + LAT);
        cur_ab = nab;
        idle(gap);
    endtask

    task automatic glitch(input bit on_a, input int len, input int gap);
        if (on_a) a_in = ~a_in;
        else      b_in = ~b_in;
        idle(len);
        if (on_a) a_in = ~a_in;
        else      b_in = ~b_in;
        idle(gap);
    endtask

    task automatic random_run(input int n);
        int r;
        for (int i = 0; i < n; i++) begin
            r = $urandom_range(0, 11);
            if (r < 6)       step_to(fwd_next(cur_ab), $urandom_range(4, 10));
            else if (r < 9)  step_to(rev_next(cur_ab), $urandom_range(4, 10));
            else if (r < 10) step_to(cur_ab ^ 2'b11, $urandom_range(4, 10));
            else             glitch($urandom_range(0, 1) == 1, $urandom_range(1, 3),
                                    $urandom_range(4, 10));
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        edges_m[0] = 4;
        edges_m[1] = 1;
        acc_m[0]   = 0;
        acc_m[1]   = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        reset  = 1'b0;
        mon_en = 1'b1;
        idle(12);

        // Forward sequence, one increment on the 4-edge lane
        step_to(2'b01, 10);
        step_to(2'b11, 10);
        step_to(2'b10, 10);
        step_to(2'b00, 10);

        // Reverse sequence
        step_to(2'b10, 10);
        step_to(2'b11, 10);
        step_to(2'b01, 10);
        step_to(2'b00, 10);

        // Glitches: 3 cycles rejected, 4 cycles accepted as two edges
        glitch(1'b1, 3, 10);
        glitch(1'b0, 3, 10);
        step_to(cur_ab ^ 2'b10, 4);
        step_to(cur_ab ^ 2'b10, 12);

        // Illegal double transition, clear, then error and clear together
        step_to(cur_ab ^ 2'b11, 12);
        err_clear = 1'b1;
        tick();
        idle(4);
        step_to(cur_ab ^ 2'b11, LAT - 1);
        err_clear = 1'b1;
        tick();
        idle(5);
        err_clear = 1'b1;
        tick();
        idle(4);

        // Reversal cancels partial steps, then a full forward step
        step_to(fwd_next(cur_ab), 8);
        step_to(fwd_next(cur_ab), 8);
        step_to(rev_next(cur_ab), 8);
        step_to(rev_next(cur_ab), 8);
        for (int i = 0; i < 4; i++) step_to(fwd_next(cur_ab), 8);
        idle(4);

        // Randomised traffic with random error clears
        rnd_clr = 1'b1;
        random_run(150);
        rnd_clr = 1'b0;
        idle(12);

        // Reset mid-operation with a partial step of 3 on the 4-edge lane
        step_to(cur_ab ^ 2'b11, 10);
        step_to(fwd_next(cur_ab), 8);
        step_to(fwd_next(cur_ab), 8);
        step_to(fwd_next(cur_ab), LAT);
        chk("pre_reset_inc1", inc1, 1'b1);
        chk("pre_reset_flag4", flag4, 1'b1);
        #2;
        reset  = 1'b1;
        mon_en = 1'b0;
        #1;
        chk_outputs_zero("async_reset");
        q0.delete();
        q1.delete();
        err_at.delete();
        acc_m[0] = 0;
        acc_m[1] = 0;
        a_in   = 1'b1;
        b_in   = 1'b0;
        cur_ab = 2'b10;
        idle(2);
        reset  = 1'b0;
        mon_en = 1'b1;
        idle(14);

        // More traffic after re-priming from 10
        rnd_clr = 1'b1;
        random_run(60);
        rnd_clr = 1'b0;
        idle(20);

        checks++;
        if (q0.size() != 0) begin
            errors++;
            $display("FAIL drain_lane0: got %0d pending events, required 0", q0.size());
        end
        checks++;
        if (q1.size() != 0) begin
            errors++;
            $display("FAIL drain_lane1: got %0d pending events, required 0", q1.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
